// File: rtl/pc_sequencer.sv
// Program counter sequencer for the MiniSys-1A fetch stage: PC/EPC registers, next-PC selection, flush/stall control.
// Optional macro PC_SEQ_ALIGN_CHECK_EN traps misaligned jump/branch targets instead of silently clearing bits[1:0].
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT_STALL
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_next;
    logic [31:0] epc_next;
    logic        flush_next;
    logic [31:0] redir_target;

    assign pc_plus4    = pc + 32'd4;
    assign fetch_valid = (state == RUN);

`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic addr_err_next;
`else
    // Low target bits are discarded in this build.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^{jump_target[1:0], branch_target[1:0]};
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        epc_next     = epc;
        flush_next   = 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        addr_err_next = 1'b0;
`endif
        redir_target = jump ? jump_target : branch_target;

        case (state)
            BOOT: state_next = RUN;
            RUN, HALT_STALL: begin
                state_next = RUN;
                if (exc_req) begin
                    epc_next   = pc;
                    pc_next    = EXC_VECTOR;
                    flush_next = 1'b1;
                end else if (eret) begin
                    pc_next    = epc;
                    flush_next = 1'b1;
                end else if (stall) begin
                    // Jump/branch requesters keep their request up until stall drops.
                    state_next = HALT_STALL;
                end else if (jump || branch_taken) begin
                    flush_next = 1'b1;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                    if (redir_target[1:0] != 2'b00) begin
                        addr_err_next = 1'b1;
                        epc_next      = pc;
                        pc_next       = EXC_VECTOR;
                    end else begin
                        pc_next = redir_target;
                    end
`else
                    pc_next = {redir_target[31:2], 2'b00};
`endif
                end else begin
                    pc_next = pc_plus4;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
            epc   <= 32'h0000_0000;
            flush <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            epc   <= epc_next;
            flush <= flush_next;
        end
    end

`ifdef PC_SEQ_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_err <= 1'b0;
        else     addr_err <= addr_err_next;
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule
